// File: rtl/abus_owner_if.sv
// Bus bundle between the abus masters, the lower-first arbiter and the single slave port.
// The slave modport is the ownership stage's view. The master modport is the surrounding fabric's view.
interface abus_owner_if #(
  parameter int N  = 8,
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_last;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_ready;
  logic [DW-1:0]   m_rdata;
  logic            s_valid;
  logic            s_ready;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   s_rdata;
  logic [N-1:0]    owner;
  logic            busy;
  logic            err;

  modport slave (
    input  req, grant, m_valid, m_last, m_we, m_addr, m_wdata, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_we, s_addr, s_wdata, owner, busy, err
  );

  modport master (
    output req, grant, m_valid, m_last, m_we, m_addr, m_wdata, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_we, s_addr, s_wdata, owner, busy, err
  );
endinterface

// File: rtl/abus_owner.sv
// Bus ownership stage: locks the arbiter's grant for a burst and muxes the owner onto the slave port.
// Release happens on a last beat, at the burst limit, or on a request drop, followed by one turnaround cycle.
module abus_owner #(
  parameter int N         = 8,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rstn,
  abus_owner_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN, REL} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   owner_q, owner_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, cnt_inc;
  logic           err_q, err_nxt;

  logic           own;
  logic           sel_valid, sel_last, sel_req, sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           accept, at_limit, grant_onehot, grant_legal;

  // owner_q is one-hot or zero, so an AND-OR mux selects the owner's channel.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N; i++) begin
      sel_valid = sel_valid | (owner_q[i] & bus.m_valid[i]);
      sel_last  = sel_last  | (owner_q[i] & bus.m_last[i]);
      sel_req   = sel_req   | (owner_q[i] & bus.req[i]);
      sel_we    = sel_we    | (owner_q[i] & bus.m_we[i]);
      sel_addr  = sel_addr  | (bus.m_addr[i*AW +: AW]  & {AW{owner_q[i]}});
      sel_wdata = sel_wdata | (bus.m_wdata[i*DW +: DW] & {DW{owner_q[i]}});
    end
  end

  assign own         = (state == OWN);
  assign bus.s_valid = own & sel_valid;
  assign bus.m_ready = (own & bus.s_ready) ? owner_q : '0;
  assign bus.s_we    = own & sel_we;
  assign bus.s_addr  = own ? sel_addr  : '0;
  assign bus.s_wdata = own ? sel_wdata : '0;
  assign bus.m_rdata = bus.s_rdata;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state != IDLE);
  assign bus.err     = err_q;

  assign accept   = bus.s_valid & bus.s_ready;
  assign cnt_inc  = cnt + CW'(1);
  assign at_limit = (cnt_inc == CW'(MAX_BURST));

  // A power of two has no bits left after clearing its lowest set bit.
  assign grant_onehot = (bus.grant != '0) && ((bus.grant & (bus.grant - N'(1))) == '0);
  assign grant_legal  = grant_onehot && ((bus.grant & bus.req) != '0);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner_q;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req != '0) begin
          if (grant_legal) begin
            owner_nxt = bus.grant;
            cnt_nxt   = '0;
            state_nxt = OWN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      OWN: begin
        if (accept) cnt_nxt = cnt_inc;
        // A drop only counts once no beat is pending, so a raised s_valid is never withdrawn.
        if ((accept && (sel_last || at_limit)) || (!sel_req && !sel_valid)) begin
          owner_nxt = '0;
          state_nxt = REL;
        end
      end
      REL: begin
        owner_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        owner_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      owner_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register update from the same pre-edge values.
      state   <= state_nxt;
      owner_q <= owner_nxt;
      cnt     <= cnt_nxt;
      err_q   <= err_nxt;
    end
  end
endmodule
